// File: rtl/lb_recomplement_gate.sv
// Purpose: serial two's-complement to sign-magnitude converter for the late bus (single and double-precision lines).
// Latency: exactly one CLOCK from IB to LB; LB_TS is aligned with LB.
// Backpressure: none; a continuous bit stream with no gaps between words.
module lb_recomplement_gate #(
  parameter int WORD_BITS = 29,
  parameter int CNT_W     = 5
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic IB,
  input  logic TS,
  input  logic DP,
  input  logic CMPL_EN,
  input  logic FO_CLR,
  output logic LB,
  output logic LB_TS,
  output logic NEG,
  output logic FO,
  output logic FRAME_ERR
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_POS      = 2'd1;
  localparam logic [1:0] ST_NEG_COPY = 2'd2;
  localparam logic [1:0] ST_NEG_INV  = 2'd3;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WORD_BITS - 2);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Parity the next word will have when its TS arrives (1 = odd word of a DP pair).
  logic             odd_next, odd_next_nxt;
  // Current word is the last (or only) word of its line, where overflow is judged.
  logic             cur_final, cur_final_nxt;
  logic             lb_nxt, neg_nxt;
  logic             frame_hit, word_odd, sign_ts, fo_set;

  // Next-state, conversion and flag-event decode for the bit presented this cycle.
  always_comb begin
    frame_hit     = TS && (cnt != LAST) && (state != ST_IDLE);
    // A misaligned TS always restarts as an even, sign-bearing word.
    word_odd      = TS && DP && odd_next && !frame_hit;
    sign_ts       = TS && !word_odd;
    cnt_nxt       = TS ? '0 : ((cnt == LAST) ? cnt : cnt + 1'b1);
    odd_next_nxt  = odd_next;
    cur_final_nxt = cur_final;
    neg_nxt       = NEG;
    state_nxt     = state;
    lb_nxt        = IB;

    if (TS) begin
      odd_next_nxt  = DP && !word_odd;
      cur_final_nxt = !DP || word_odd;
    end

    if (sign_ts) begin
      // Sign passes through unaltered and selects the conversion for the line.
      neg_nxt   = IB;
      state_nxt = (CMPL_EN && IB) ? ST_NEG_COPY : ST_POS;
      lb_nxt    = IB;
    end else begin
      case (state)
        ST_POS:      lb_nxt = IB;
        ST_NEG_COPY: begin
          // Copy up to and including the first 1, then invert the rest.
          lb_nxt = IB;
          if (IB) state_nxt = ST_NEG_INV;
        end
        ST_NEG_INV:  lb_nxt = ~IB;
        default:     lb_nxt = IB;
      endcase
    end

    // Still copying after the final magnitude bit means the magnitude was all
    // zero: the most negative value, which sign-magnitude cannot hold.
    fo_set = !TS && (cnt == LAST_M1) && cur_final &&
             (state == ST_NEG_COPY) && !IB;
  end

  // Registered state, outputs and sticky flags (set wins over clear).
  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      odd_next  <= 1'b0;
      cur_final <= 1'b0;
      LB        <= 1'b0;
      LB_TS     <= 1'b0;
      NEG       <= 1'b0;
      FO        <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      odd_next  <= odd_next_nxt;
      cur_final <= cur_final_nxt;
      LB        <= lb_nxt;
      LB_TS     <= TS;
      NEG       <= neg_nxt;
      FO        <= fo_set || (FO && !FO_CLR);
      FRAME_ERR <= frame_hit || (FRAME_ERR && !FO_CLR);
    end
  end

endmodule

// File: tb/tb_lb_recomplement_gate.sv
// Bench for lb_recomplement_gate: directed words with hand-computed late-bus images.
// Stimulus pushes the expected output for each bit; a monitor pops one cycle later.
// Checks LB, LB_TS, NEG, FO and FRAME_ERR on every bit.
module tb_lb_recomplement_gate;

  logic CLOCK, rst, IB, TS, DP, CMPL_EN, FO_CLR;
  logic LB, LB_TS, NEG, FO, FRAME_ERR;

  lb_recomplement_gate #(.WORD_BITS(29), .CNT_W(5)) dut (
    .CLOCK(CLOCK), .rst(rst), .IB(IB), .TS(TS), .DP(DP), .CMPL_EN(CMPL_EN),
    .FO_CLR(FO_CLR), .LB(LB), .LB_TS(LB_TS), .NEG(NEG), .FO(FO), .FRAME_ERR(FRAME_ERR)
  );

  typedef struct {
    logic lb;
    logic lbts;
    logic neg;
    logic fo;
    logic fe;
    int   due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic e_neg = 1'b0;
  logic e_fo  = 1'b0;
  logic e_fe  = 1'b0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, got, want);
    end
  endtask

  // Monitor: compare every output whose expectation is due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK);
      #3;
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("lb", cyc, LB, e.lb);
        chk("lb_ts", cyc, LB_TS, e.lbts);
        chk("neg", cyc, NEG, e.neg);
        chk("fo", cyc, FO, e.fo);
        chk("frame_err", cyc, FRAME_ERR, e.fe);
      end
    end
  end

  // One bit time: drive inputs just after an edge, expect the result after the next edge.
  task automatic step(input logic ib, input logic ts, input logic dp, input logic en,
                      input logic clr, input logic r, input logic elb, input logic elbts);
    exp_t e;
    @(posedge CLOCK);
    #1;
    IB = ib; TS = ts; DP = dp; CMPL_EN = en; FO_CLR = clr; rst = r;
    e.lb = elb; e.lbts = elbts; e.neg = e_neg; e.fo = e_fo; e.fe = e_fe;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Drive one word (slot 0 = TS slot) and its expected late-bus image.
  task automatic send_word(input logic [28:0] din, input logic [28:0] dexp,
                           input logic dp, input logic en, input logic sign_word,
                           input int nbits, input int clr_at, input logic fo_set,
                           input logic fe_set);
    logic clr;
    for (int i = 0; i < nbits; i++) begin
      clr = (i == clr_at);
      if (clr) begin
        e_fo = 1'b0;
        e_fe = 1'b0;
      end
      if (i == 28 && fo_set) e_fo = 1'b1;
      if (i == 0 && fe_set) e_fe = 1'b1;
      if (i == 0 && sign_word) e_neg = din[0];
      step(din[i], i == 0, dp, en, clr, 1'b1, dexp[i], i == 0);
    end
  endtask

  localparam logic [28:0] POS5   = {28'd5, 1'b0};
  localparam logic [28:0] NEG5_I = {28'hFFFFFFB, 1'b1};
  localparam logic [28:0] NEG5_O = {28'd5, 1'b1};
  localparam logic [28:0] NEG1_I = {28'hFFFFFFF, 1'b1};
  localparam logic [28:0] NEG1_O = {28'd1, 1'b1};
  localparam logic [28:0] ONES   = 29'h1FFFFFFF;
  localparam logic [28:0] ZEROS  = 29'h0;
  localparam logic [28:0] NEGZ   = {28'd0, 1'b1};

  initial begin
    rst = 1'b0; IB = 1'b0; TS = 1'b0; DP = 1'b0; CMPL_EN = 1'b0; FO_CLR = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Positive 5, negative -5, DP pair -1 (odd word converts to all zeros).
    send_word(POS5,   POS5,   1'b0, 1'b1, 1'b1, 29, -1, 1'b0, 1'b0);
    send_word(NEG5_I, NEG5_O, 1'b0, 1'b1, 1'b1, 29, -1, 1'b0, 1'b0);
    send_word(NEG1_I, NEG1_O, 1'b1, 1'b1, 1'b1, 29, -1, 1'b0, 1'b0);
    send_word(ONES,   ZEROS,  1'b1, 1'b1, 1'b0, 29, -1, 1'b0, 1'b0);

    // Negative zero overflows; clear it; overflow again with a same-cycle clear.
    send_word(NEGZ, NEGZ, 1'b0, 1'b1, 1'b1, 29, -1, 1'b1, 1'b0);
    send_word(POS5, POS5, 1'b0, 1'b1, 1'b1, 29,  3, 1'b0, 1'b0);
    send_word(NEGZ, NEGZ, 1'b0, 1'b1, 1'b1, 29, 28, 1'b1, 1'b0);

    // Misaligned TS at bit 10 of a negative word: resync as a new positive word.
    send_word(NEG5_I, NEG5_O, 1'b0, 1'b1, 1'b1, 10,  2, 1'b0, 1'b0);
    send_word(POS5,   POS5,   1'b0, 1'b1, 1'b1, 29, -1, 1'b0, 1'b1);

    // Conversion disabled: negative word passes unchanged.
    send_word(NEG5_I, NEG5_I, 1'b0, 1'b0, 1'b1, 29, -1, 1'b0, 1'b0);

    // Reset in the middle of an even DP word while inverting.
    send_word(NEG1_I, NEG1_O, 1'b1, 1'b1, 1'b1, 16, -1, 1'b0, 1'b0);
    e_neg = 1'b0; e_fo = 1'b0; e_fe = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh even word after reset, then its odd partner, then a single word.
    send_word(NEG1_I, NEG1_O, 1'b1, 1'b1, 1'b1, 29, -1, 1'b0, 1'b0);
    send_word(ONES,   ZEROS,  1'b1, 1'b1, 1'b0, 29, -1, 1'b0, 1'b0);
    send_word(NEG5_I, NEG5_O, 1'b0, 1'b1, 1'b1, 29, -1, 1'b0, 1'b0);

    @(posedge CLOCK);
    @(posedge CLOCK);
    #5;
    chk("scoreboard_drained", cyc, q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
